aftab_daru: RTL and testbench
=============================

// Module: aftab_daru
// PURPOSE
//  Data Adjustment Read Unit: read-side peer of the DAWU on the AFTAB byte-wide memory port.
//  For loads (LB/LBU/LH/LHU/LW), fetches 1/2/4 bytes one at a time, little-endian, from consecutive addresses.
//  Assembles and sign/zero-extends the bytes into a 32-bit word, then pulses completeDARU to the main controller.
// PARAMETERS
//  ADDR_W  32  address width
//  DATA_W  32  assembled output width (fixed 32; any other value is unsupported)
// PORTS
//  clk           in   1   clock, rising edge
//  rst           in   1   asynchronous, active-high reset
//  startDARU     in   1   start request; sampled only in IDLE
//  nBytes        in   2   00=byte, 01=half, 10=word, 11=word (treated as 10)
//  signExt       in   1   1=sign-extend result, 0=zero-extend (ignored for word)
//  addrIn        in   32  base byte address, latched on start
//  memRdy        in   1   memory returned memDataIn for the current memAddr this cycle
//  memDataIn     in   8   read byte
//  memAddr       out  32  addrReg + cnt
//  readMem       out  1   read request, high throughout READ
//  dataOut       out  32  assembled result; registered; held until next accepted start
//  completeDARU  out  1   one-cycle done pulse
//  busy          out  1   high in READ and DONE
//  misaligned    out  1   misalignment flag; see CONFIGURATION
// BEHAVIOUR
//  Reset: FSM=IDLE; cnt, addrReg, sizeReg, sgnReg, byte buffer, dataOut = 0; all outputs 0.
//  Reset is asynchronous and may hit mid-operation: readMem drops immediately, no completion pulse, partial bytes discarded.
//  IDLE:
//   - startDARU=1 latches addrIn, nBytes (11->10), signExt; cnt:=0; byte buffer:=0; next state READ.
//  READ:
//   - readMem=1; memAddr=addrReg+cnt (wraps modulo 2^32).
//   - memRdy=1: buffer byte lane [cnt] := memDataIn, cnt++.
//   - memRdy=1 on the last byte (cnt==N-1; N=1/2/4): next state DONE.
//   - memRdy=0: hold state; readMem and memAddr stay stable.
//  DONE (one cycle):
//   - completeDARU=1; dataOut := extended buffer:
//     - byte: {24{sgn&b0[7]}},b0
//     - half: {16{sgn&b1[7]}},b1,b0
//     - word: b3..b0
//   - next state IDLE.
//  Latency: start sampled at cycle 0, reads in cycles 1..N with memRdy every cycle, completeDARU at cycle N+1.
//  dataOut is valid from the cycle after DONE.
//  startDARU while busy is ignored; a new start is accepted in the IDLE cycle after DONE at the earliest.
//  Counter is 2 bits; it never passes N-1 because the FSM leaves READ at that point.
// CONFIGURATION
//  AFTAB_DARU_MISALIGN_EN defined:
//   - On start, half with addrIn[0]!=0 or word with addrIn[1:0]!=0 goes IDLE->DONE with no READ cycles.
//   - readMem is never asserted for that access; dataOut := 0.
//   - misaligned=1 together with completeDARU for that one cycle.
//  Not defined: no alignment check; all accesses are read byte-wise; misaligned tied 0.
// STRUCTURE
//  Package aftab_daru_pkg:
//   - state encodings IDLE/READ/DONE (2 bits)
//   - nBytes encodings SZ_BYTE/SZ_HALF/SZ_WORD
//   - function last_cnt(size) returning N-1
//  Sub-module aftab_DARU_controller (FSM):
//   - inputs startDARU, memRdy, lastByte, misalign
//   - outputs ldRegs, zeroBuf, ldByte, incCnt, ldOut, readMem, completeDARU
//  Top-level datapath: address/count/size registers, byte buffer, extension mux, output register.
// TESTING
//  1 LBU: addrIn=0x100, nBytes=00, signExt=0, memRdy=1, memDataIn=0x80
//    -> one readMem cycle at 0x100; completeDARU at cycle 2; dataOut=0x00000080.
//  2 LH: addrIn=0x200, bytes 0x34,0xF2, memRdy=1
//    -> memAddr 0x200 then 0x201; dataOut=0xFFFFF234.
//  3 LW with stalls: addrIn=0x300, memRdy low 2 cycles before each byte, bytes 11,22,33,44
//    -> memAddr holds per byte; dataOut=0x44332211; exactly one completeDARU.
//  4 rst asserted after 2nd byte of LW -> readMem=0 same cycle, dataOut=0, no completeDARU; fresh LB then succeeds.
//  5 startDARU pulsed during READ -> ignored; result of first access unaffected.
//  6 (AFTAB_DARU_MISALIGN_EN) LW at 0x402
//    -> readMem never high; completeDARU and misaligned high at cycle 1; dataOut=0.

Source files
------------

// File: rtl/aftab_daru_pkg.sv
// aftab_daru_pkg: shared encodings and helpers for the AFTAB Data Adjustment
// Read Unit (state codes, access-size codes, byte-count helpers).
package aftab_daru_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    READ = 2'b01,
    DONE = 2'b10
  } state_t;

  // Access size as carried on nBytes; 2'b11 is folded onto SZ_WORD on capture
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_t;

  // Fold the raw nBytes code onto a legal size
  function automatic size_t norm_size(input logic [1:0] nb);
    case (nb)
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  // Index of the last byte of an access (N-1)
  function automatic logic [1:0] last_cnt(input size_t size);
    case (size)
      SZ_BYTE: return 2'd0;
      SZ_HALF: return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  // Natural-alignment test on the two low address bits
  function automatic logic is_misaligned(input size_t size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      default: return (addr_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/aftab_daru_controller.sv
// aftab_DARU_controller: IDLE/READ/DONE sequencer of the read unit.
// Module outputs (readMem, completeDARU, busy, ldOut, misaligned) are
// registered; the per-cycle datapath strobes are decoded from the state.
module aftab_DARU_controller
  import aftab_daru_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic startDARU,
  input  logic memRdy,
  input  logic lastByte,
  input  logic misalign,
  output logic ldRegs,
  output logic zeroBuf,
  output logic ldByte,
  output logic incCnt,
  output logic ldOut,
  output logic readMem,
  output logic completeDARU,
  output logic busy,
  output logic misaligned
);

  state_t state;

  // State register plus registered outputs, all derived from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      readMem      <= 1'b0;
      completeDARU <= 1'b0;
      busy         <= 1'b0;
      ldOut        <= 1'b0;
      misaligned   <= 1'b0;
    end else begin
      readMem      <= 1'b0;
      completeDARU <= 1'b0;
      ldOut        <= 1'b0;
      misaligned   <= 1'b0;
      busy         <= 1'b0;
      case (state)
        IDLE: begin
          if (startDARU) begin
            busy <= 1'b1;
            if (misalign) begin
              // Rejected access: report straight away, never touch memory
              state        <= DONE;
              completeDARU <= 1'b1;
              ldOut        <= 1'b1;
              misaligned   <= 1'b1;
            end else begin
              state   <= READ;
              readMem <= 1'b1;
            end
          end
        end
        READ: begin
          busy <= 1'b1;
          if (memRdy && lastByte) begin
            state        <= DONE;
            completeDARU <= 1'b1;
            ldOut        <= 1'b1;
          end else begin
            readMem <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Datapath strobes that must act in the cycle the condition is seen
  always_comb begin
    ldRegs  = (state == IDLE) && startDARU;
    zeroBuf = (state == IDLE) && startDARU;
    ldByte  = (state == READ) && memRdy;
    incCnt  = (state == READ) && memRdy;
  end

endmodule

// File: rtl/aftab_daru.sv
// aftab_daru: Data Adjustment Read Unit. Reads 1/2/4 bytes little-endian over
// the byte-wide memory port, sign/zero-extends them into dataOut and pulses
// completeDARU. Optional feature macro: AFTAB_DARU_MISALIGN_EN (reject
// misaligned half/word accesses without reading memory).
module aftab_daru
  import aftab_daru_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              startDARU,
  input  logic [1:0]        nBytes,
  input  logic              signExt,
  input  logic [ADDR_W-1:0] addrIn,
  input  logic              memRdy,
  input  logic [7:0]        memDataIn,
  output logic [ADDR_W-1:0] memAddr,
  output logic              readMem,
  output logic [DATA_W-1:0] dataOut,
  output logic              completeDARU,
  output logic              busy,
  output logic              misaligned
);

  logic [ADDR_W-1:0] addr_reg;
  logic [1:0]        cnt_reg;
  size_t             size_reg;
  logic              sgn_reg;
  logic [7:0]        byte_buf_reg [4];
  logic [31:0]       ext_word;

  logic ld_regs, zero_buf, ld_byte, inc_cnt, ld_out;
  logic last_byte, misalign;

  assign last_byte = (cnt_reg == last_cnt(size_reg));
  assign memAddr   = addr_reg + ADDR_W'(cnt_reg);

`ifdef AFTAB_DARU_MISALIGN_EN
  assign misalign = is_misaligned(norm_size(nBytes), addrIn[1:0]);
`else
  assign misalign = 1'b0;
`endif

  aftab_DARU_controller u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .startDARU    (startDARU),
    .memRdy       (memRdy),
    .lastByte     (last_byte),
    .misalign     (misalign),
    .ldRegs       (ld_regs),
    .zeroBuf      (zero_buf),
    .ldByte       (ld_byte),
    .incCnt       (inc_cnt),
    .ldOut        (ld_out),
    .readMem      (readMem),
    .completeDARU (completeDARU),
    .busy         (busy),
    .misaligned   (misaligned)
  );

  // Capture the access parameters when a start is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg <= '0;
      size_reg <= SZ_BYTE;
      sgn_reg  <= 1'b0;
    end else if (ld_regs) begin
      addr_reg <= addrIn;
      size_reg <= norm_size(nBytes);
      sgn_reg  <= signExt;
    end
  end

  // Byte counter: cleared on start, advanced on every accepted byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= 2'd0;
    end else if (ld_regs) begin
      cnt_reg <= 2'd0;
    end else if (inc_cnt) begin
      cnt_reg <= cnt_reg + 2'd1;
    end
  end

  // One register per byte lane; lane gi takes memDataIn when cnt points at it
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        byte_buf_reg[gi] <= 8'h00;
      end else if (zero_buf) begin
        byte_buf_reg[gi] <= 8'h00;
      end else if (ld_byte && (cnt_reg == 2'(gi))) begin
        byte_buf_reg[gi] <= memDataIn;
      end
    end
  end

  // Extension of the assembled bytes according to the latched size/sign
  always_comb begin
    ext_word = {byte_buf_reg[3], byte_buf_reg[2], byte_buf_reg[1], byte_buf_reg[0]};
    case (size_reg)
      SZ_BYTE: ext_word = {{24{sgn_reg & byte_buf_reg[0][7]}}, byte_buf_reg[0]};
      SZ_HALF: ext_word = {{16{sgn_reg & byte_buf_reg[1][7]}}, byte_buf_reg[1], byte_buf_reg[0]};
      default: ext_word = {byte_buf_reg[3], byte_buf_reg[2], byte_buf_reg[1], byte_buf_reg[0]};
    endcase
  end

  // Output register: loaded at the end of DONE, held until the next result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dataOut <= '0;
    end else if (ld_out) begin
      dataOut <= misaligned ? '0 : ext_word;
    end
  end

endmodule

// File: tb/tb_aftab_daru.sv
// tb_aftab_daru: scoreboard bench for aftab_daru. Expected addresses and
// results are queued when a load is issued; a memory responder and a result
// monitor pop and compare them as the DUT produces them.
module tb_aftab_daru;

  logic        clk = 1'b0;
  logic        rst;
  logic        startDARU;
  logic [1:0]  nBytes;
  logic        signExt;
  logic [31:0] addrIn;
  logic        memRdy;
  logic [7:0]  memDataIn;
  logic [31:0] memAddr;
  logic        readMem;
  logic [31:0] dataOut;
  logic        completeDARU;
  logic        busy;
  logic        misaligned;

  aftab_daru #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .startDARU    (startDARU),
    .nBytes       (nBytes),
    .signExt      (signExt),
    .addrIn       (addrIn),
    .memRdy       (memRdy),
    .memDataIn    (memDataIn),
    .memAddr      (memAddr),
    .readMem      (readMem),
    .dataOut      (dataOut),
    .completeDARU (completeDARU),
    .busy         (busy),
    .misaligned   (misaligned)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_addr_q [$];
  logic [31:0] exp_data_q [$];
  logic        exp_mis_q  [$];
  logic [7:0]  mem [logic [31:0]];

  int cyc = 0;
  int stall_cfg = 0;
  int wait_cnt = 0;
  int grant_cnt = 0;
  int read_cycles = 0;
  int done_cnt = 0;
  int t_done = 0;
  bit done_seen = 0;
  bit result_pending = 0;
  logic [31:0] pend_data;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Memory responder: checks memAddr against the expected address stream on
  // every READ cycle (stalls included) and answers after stall_cfg waits
  always @(negedge clk) begin
    if (rst) begin
      memRdy   = 1'b0;
      wait_cnt = 0;
    end else if (readMem) begin
      read_cycles++;
      if (exp_addr_q.size() == 0) begin
        check_eq("spurious_read", {31'b0, readMem}, 32'd0);
        memRdy = 1'b0;
      end else begin
        check_eq("mem_addr", memAddr, exp_addr_q[0]);
        if (wait_cnt < stall_cfg) begin
          memRdy    = 1'b0;
          memDataIn = 8'($urandom);
          wait_cnt++;
        end else begin
          memRdy    = 1'b1;
          memDataIn = mem.exists(memAddr) ? mem[memAddr] : 8'h00;
          void'(exp_addr_q.pop_front());
          wait_cnt = 0;
          grant_cnt++;
        end
      end
    end else begin
      memRdy    = 1'b0;
      memDataIn = 8'($urandom);
      wait_cnt  = 0;
    end
  end

  // Result monitor: completion pops the scoreboard, dataOut checked a cycle later
  always @(negedge clk) begin
    if (result_pending) begin
      check_eq("data_out", dataOut, pend_data);
      result_pending = 0;
    end
    if (completeDARU) begin
      done_cnt++;
      t_done    = cyc;
      done_seen = 1;
      if (exp_data_q.size() == 0) begin
        check_eq("spurious_complete", {31'b0, completeDARU}, 32'd0);
      end else begin
        pend_data = exp_data_q.pop_front();
        check_eq("misaligned", {31'b0, misaligned}, {31'b0, exp_mis_q.pop_front()});
        check_eq("busy_in_done", {31'b0, busy}, 32'd1);
        result_pending = 1;
      end
    end else if (misaligned) begin
      check_eq("misaligned_stray", {31'b0, misaligned}, 32'd0);
    end
  end

  // Issue one load, queue its expectations, wait for and check completion
  task automatic do_load(input logic [31:0] a, input logic [1:0] nb, input logic sg,
                         input int stalls, input logic [31:0] word, input bit pulse_mid);
    int n;
    int c0;
    int d0;
    int r0;
    int exp_lat;
    int exp_reads;
    bit mis;
    logic [7:0]  b [4];
    logic [31:0] expd;
    n = (nb == 2'b00) ? 1 : (nb == 2'b01) ? 2 : 4;
    for (int i = 0; i < 4; i++) begin
      b[i] = word[8*i +: 8];
      mem[a + 32'(i)] = b[i];
    end
    mis = 0;
`ifdef AFTAB_DARU_MISALIGN_EN
    mis = ((n == 2) && a[0]) || ((n == 4) && (a[1:0] != 2'b00));
`endif
    case (n)
      1:       expd = {{24{sg & b[0][7]}}, b[0]};
      2:       expd = {{16{sg & b[1][7]}}, b[1], b[0]};
      default: expd = {b[3], b[2], b[1], b[0]};
    endcase
    if (mis) expd = 32'd0;
    if (!mis) begin
      for (int i = 0; i < n; i++) exp_addr_q.push_back(a + 32'(i));
    end
    exp_data_q.push_back(expd);
    exp_mis_q.push_back(mis);
    exp_lat   = mis ? 1 : n * (stalls + 1) + 1;
    exp_reads = mis ? 0 : n * (stalls + 1);
    stall_cfg = stalls;
    d0 = done_cnt;
    r0 = read_cycles;
    done_seen = 0;

    @(negedge clk);
    addrIn = a; nBytes = nb; signExt = sg; startDARU = 1'b1;
    @(posedge clk);
    #1;
    c0 = cyc;
    startDARU = 1'b0;
    addrIn  = $urandom;
    nBytes  = 2'($urandom);
    signExt = 1'($urandom);
    if (pulse_mid) begin
      @(negedge clk);
      @(negedge clk);
      addrIn = 32'h0BAD_0000; nBytes = 2'b10; signExt = 1'b1; startDARU = 1'b1;
      @(negedge clk);
      startDARU = 1'b0;
    end
    for (int k = 0; k < 200 && !done_seen; k++) @(negedge clk);
    check_eq("done_seen", {31'b0, done_seen}, 32'd1);
    if (done_seen) check_eq("latency", 32'(t_done - c0 + 1), 32'(exp_lat));
    repeat (3) @(negedge clk);
    check_eq("one_complete", 32'(done_cnt - d0), 32'd1);
    check_eq("read_cycles", 32'(read_cycles - r0), 32'(exp_reads));
    check_eq("idle_busy", {31'b0, busy}, 32'd0);
    $display("load addr=0x%08h nb=%0d sgn=%0d stalls=%0d -> dataOut=0x%08h", a, nb, sg, stalls, dataOut);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0;
    int d0;
    rst = 1'b1; startDARU = 1'b0; nBytes = 2'b00; signExt = 1'b0; addrIn = 32'd0;
    memRdy = 1'b0; memDataIn = 8'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_readMem", {31'b0, readMem}, 32'd0);
    check_eq("rst_complete", {31'b0, completeDARU}, 32'd0);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_misaligned", {31'b0, misaligned}, 32'd0);
    check_eq("rst_dataOut", dataOut, 32'd0);
    check_eq("rst_memAddr", memAddr, 32'd0);
    rst = 1'b0;
    $display("reset released");

    // LBU, LH, stalled LW
    do_load(32'h0000_0100, 2'b00, 1'b0, 0, 32'h0000_0080, 0);
    do_load(32'h0000_0200, 2'b01, 1'b1, 0, 32'h0000_F234, 0);
    do_load(32'h0000_0300, 2'b10, 1'b0, 2, 32'h4433_2211, 0);
    // Extension corners and the 2'b11 size code, including address wrap
    do_load(32'h0000_0110, 2'b00, 1'b1, 0, 32'h0000_007F, 0);
    do_load(32'h0000_0111, 2'b00, 1'b1, 1, 32'h0000_00A5, 0);
    do_load(32'h0000_0220, 2'b01, 1'b0, 0, 32'h0000_8001, 0);
    do_load(32'hFFFF_FFFE, 2'b11, 1'b1, 0, 32'h89AB_CDEF, 0);

    // Reset after the second byte of a LW
    for (int i = 0; i < 4; i++) begin
      mem[32'h500 + 32'(i)] = 8'h60 + 8'(i);
      exp_addr_q.push_back(32'h500 + 32'(i));
    end
    stall_cfg = 0;
    g0 = grant_cnt;
    d0 = done_cnt;
    @(negedge clk);
    addrIn = 32'h500; nBytes = 2'b10; signExt = 1'b0; startDARU = 1'b1;
    @(negedge clk);
    startDARU = 1'b0;
    for (int k = 0; k < 50 && grant_cnt < g0 + 2; k++) @(posedge clk);
    check_eq("two_grants", 32'(grant_cnt - g0), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_readMem", {31'b0, readMem}, 32'd0);
    check_eq("mid_rst_busy", {31'b0, busy}, 32'd0);
    check_eq("mid_rst_dataOut", dataOut, 32'd0);
    exp_addr_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("mid_rst_no_complete", 32'(done_cnt - d0), 32'd0);
    $display("reset during LW: dataOut=0x%08h", dataOut);
    do_load(32'h0000_0600, 2'b00, 1'b1, 0, 32'h0000_009C, 0);

    // Start pulsed while a LH is stalled in READ
    do_load(32'h0000_0240, 2'b01, 1'b1, 3, 32'h0000_8155, 1);

    // Misaligned half/word (rejected only when the alignment check is built in)
    do_load(32'h0000_0402, 2'b10, 1'b0, 0, 32'hDEAD_BEEF, 0);
    do_load(32'h0000_0201, 2'b01, 1'b1, 0, 32'h0000_C0DE, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
